axi_crossbar_addr_pipe: RTL and testbench



---
 rtl/axi_crossbar_addr_pipe.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axi_crossbar_addr_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_addr_pipe.sv
// axi_crossbar_addr_pipe: per-slave AXI address decode, admission
// control and ID-thread tracking in front of the AW/AR arbiter.
module axi_crossbar_addr_pipe #(
  parameter int S          = 0,
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int S_THREADS  = 2,
  parameter int S_ACCEPT   = 16,
  parameter int M_REGIONS  = 1,
  parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
  parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH =
    {M_COUNT{{M_REGIONS{32'd24}}}},
  parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = '1,
  parameter logic [M_COUNT-1:0] M_SECURE = '0,
  parameter logic [M_COUNT*32-1:0] M_ISSUE = '0,
  parameter bit WC_OUTPUT = 1'b0,
  localparam int SW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
  localparam int CW = $clog2(S_ACCEPT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_aid,
  input  logic [ADDR_WIDTH-1:0] s_axi_aaddr,
  input  logic [2:0]            s_axi_aprot,
  input  logic [3:0]            s_axi_aqos,
  input  logic                  s_axi_avalid,
  output logic                  s_axi_aready,
  output logic [3:0]            m_axi_aregion,
  output logic [SW-1:0]         m_select,
  output logic                  m_axi_avalid,
  input  logic                  m_axi_aready,
  output logic [SW-1:0]         m_wc_select,
  output logic                  m_wc_decerr,
  output logic                  m_wc_valid,
  input  logic                  m_wc_ready,
  output logic                  m_rc_decerr,
  output logic                  m_rc_valid,
  input  logic                  m_rc_ready,
  input  logic [ID_WIDTH-1:0]   s_cpl_id,
  input  logic                  s_cpl_valid,
  output logic [M_COUNT*CW-1:0] m_outstanding,
  output logic                  cpl_orphan
);

  localparam int NR  = M_COUNT * M_REGIONS;
  localparam int TR  = (S_THREADS < S_ACCEPT) ? S_THREADS : S_ACCEPT;
  localparam int TN  = (TR < 1) ? 1 : TR;
  localparam int TIW = (TN > 1) ? $clog2(TN) : 1;

  function automatic int rw(int k);
    return int'(M_ADDR_WIDTH[k*32 +: 32]);
  endfunction

  // Auto-packing places each enabled region at the next boundary
  // aligned to its own size.
  function automatic logic [63:0] rbase(int k);
    logic [63:0] off;
    logic [63:0] res;
    int w;
    off = '0;
    res = '0;
    if (M_BASE_ADDR != '0) begin
      res = 64'(M_BASE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]);
    end else begin
      for (int n = 0; n <= k; n++) begin
        w = rw(n);
        if (w != 0) begin
          off = (off + (64'd1 << w) - 64'd1) &
                ~((64'd1 << w) - 64'd1);
          if (n == k) res = off;
          off = off + (64'd1 << w);
        end
      end
    end
    return res;
  endfunction

  function automatic bit cfg_ok();
    bit ok;
    int wa;
    int wb;
    int wm;
    ok = 1'b1;
    for (int a = 0; a < NR; a++) begin
      wa = rw(a);
      if (wa != 0) begin
        if (wa < 12 || wa > ADDR_WIDTH) begin
          ok = 1'b0;
        end else begin
          if ((rbase(a) & ((64'd1 << wa) - 64'd1)) != '0) ok = 1'b0;
          for (int b = a + 1; b < NR; b++) begin
            wb = rw(b);
            if (wb >= 12 && wb <= ADDR_WIDTH) begin
              wm = (wa > wb) ? wa : wb;
              if ((rbase(a) >> wm) == (rbase(b) >> wm)) ok = 1'b0;
            end
          end
        end
      end
    end
    return ok;
  endfunction

  if (!cfg_ok()) begin : g_map_err
    $error("axi_crossbar_addr_pipe: illegal region map");
  end
  if (S_ACCEPT < 1 || S_THREADS < 1) begin : g_cnt_err
    $error("axi_crossbar_addr_pipe: S_ACCEPT/S_THREADS < 1");
  end

  logic [NR-1:0]       w_rhit;
  logic                w_hit;
  logic [SW-1:0]       w_sel;
  logic [3:0]          w_reg;
  logic                w_idm, w_fre, w_cpm, w_cpl;
  logic [TIW-1:0]      w_idi, w_fri, w_cpi, w_alloc;
  logic [CW-1:0]       w_tot, w_cnt;
  logic [31:0]         w_cap;
  logic                w_adm, w_free, w_start, w_thr_ok, w_cap_ok;
  logic                w_unused;

  logic                r_av, r_wv, r_rv, r_dec, r_orph;
  logic [SW-1:0]       r_sel;
  logic [3:0]          r_reg;
  logic [CW-1:0]       r_total;
  logic [CW-1:0]       r_out [M_COUNT];
  logic [ID_WIDTH-1:0] r_t_id [TN];
  logic [SW-1:0]       r_t_sel [TN];
  logic [3:0]          r_t_reg [TN];
  logic [CW-1:0]       r_t_cnt [TN];

  for (genvar k = 0; k < NR; k++) begin : g_reg
    localparam int W = rw(k);
    if (W == 0) begin : g_off
      assign w_rhit[k] = 1'b0;
    end else begin : g_on
      localparam int MI = k / M_REGIONS;
      localparam logic [63:0] B = rbase(k);
      assign w_rhit[k] =
        (!M_SECURE[MI] || !s_axi_aprot[1]) &&
        M_CONNECT[S + MI*S_COUNT] &&
        ((64'(s_axi_aaddr) >> W) == (B >> W));
    end
  end

  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_reg = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (w_rhit[k]) begin
        w_hit = 1'b1;
        w_sel = SW'(k / M_REGIONS);
        w_reg = 4'(k % M_REGIONS);
      end
    end
  end

  always_comb begin
    w_idm = 1'b0;
    w_idi = '0;
    w_fre = 1'b0;
    w_fri = '0;
    w_cpm = 1'b0;
    w_cpi = '0;
    for (int t = TN - 1; t >= 0; t--) begin
      if (r_t_cnt[t] != '0) begin
        if (r_t_id[t] == s_axi_aid) begin
          w_idm = 1'b1;
          w_idi = TIW'(t);
        end
        if (r_t_id[t] == s_cpl_id) begin
          w_cpm = 1'b1;
          w_cpi = TIW'(t);
        end
      end else begin
        w_fre = 1'b1;
        w_fri = TIW'(t);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    w_cap = '0;
    for (int m = 0; m < M_COUNT; m++) begin
      if (SW'(m) == w_sel) begin
        w_cnt = r_out[m];
        w_cap = M_ISSUE[m*32 +: 32];
      end
    end
  end

  // A completion in the same cycle frees its slot for a new start.
  assign w_cpl    = s_cpl_valid & w_cpm;
  assign w_tot    = r_total - CW'(w_cpl);
  assign w_cap_ok = (w_cap == '0) ||
    (32'(w_cnt - CW'(w_cpl && r_t_sel[w_cpi] == w_sel)) < w_cap);
  assign w_thr_ok = w_idm ?
    (r_t_sel[w_idi] == w_sel && r_t_reg[w_idi] == w_reg) : w_fre;
  assign w_adm    = w_hit && (w_tot < CW'(S_ACCEPT)) &&
                    w_cap_ok && w_thr_ok;
  assign w_free   = (!r_av || m_axi_aready) &&
                    (!r_wv || m_wc_ready || !WC_OUTPUT) &&
                    (!r_rv || m_rc_ready);
  assign s_axi_aready = !rst && s_axi_avalid && w_free &&
                        (!w_hit || w_adm);
  assign w_start  = s_axi_aready && w_hit;
  assign w_alloc  = w_idm ? w_idi : w_fri;
  assign w_unused = ^{s_axi_aqos, s_axi_aprot[2], s_axi_aprot[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_av    <= 1'b0;
      r_wv    <= 1'b0;
      r_rv    <= 1'b0;
      r_dec   <= 1'b0;
      r_orph  <= 1'b0;
      r_sel   <= '0;
      r_reg   <= '0;
      r_total <= '0;
      for (int m = 0; m < M_COUNT; m++) r_out[m] <= '0;
      for (int t = 0; t < TN; t++) begin
        r_t_id[t]  <= '0;
        r_t_sel[t] <= '0;
        r_t_reg[t] <= '0;
        r_t_cnt[t] <= '0;
      end
    end else begin
      if (s_axi_aready) begin
        r_av  <= w_hit;
        r_wv  <= WC_OUTPUT;
        r_rv  <= !w_hit;
        r_dec <= !w_hit;
        r_sel <= w_sel;
        r_reg <= w_reg;
      end else begin
        if (m_axi_aready) r_av <= 1'b0;
        if (m_wc_ready)   r_wv <= 1'b0;
        if (m_rc_ready)   r_rv <= 1'b0;
      end
      r_orph  <= s_cpl_valid && !w_cpm;
      r_total <= r_total + CW'(w_start) - CW'(w_cpl);
      for (int m = 0; m < M_COUNT; m++) begin
        r_out[m] <= r_out[m]
          + CW'(w_start && w_sel == SW'(m))
          - CW'(w_cpl && r_t_sel[w_cpi] == SW'(m));
      end
      for (int t = 0; t < TN; t++) begin
        r_t_cnt[t] <= r_t_cnt[t]
          + CW'(w_start && w_alloc == TIW'(t))
          - CW'(w_cpl && w_cpi == TIW'(t));
        if (w_start && w_alloc == TIW'(t)) begin
          r_t_id[t]  <= s_axi_aid;
          r_t_sel[t] <= w_sel;
          r_t_reg[t] <= w_reg;
        end
      end
    end
  end

  for (genvar m = 0; m < M_COUNT; m++) begin : g_out
    assign m_outstanding[m*CW +: CW] = r_out[m];
  end

  assign m_axi_avalid  = r_av;
  assign m_wc_valid    = r_wv;
  assign m_rc_valid    = r_rv;
  assign m_wc_decerr   = r_dec;
  assign m_rc_decerr   = r_dec;
  assign m_select      = r_sel;
  assign m_wc_select   = r_sel;
  assign m_axi_aregion = r_reg;
  assign cpl_orphan    = r_orph;

endmodule

// File: tb/tb_axi_crossbar_addr_pipe.sv
// tb_axi_crossbar_addr_pipe: directed plus random stimulus checked
// against a transaction-list reference model.
module tb_axi_crossbar_addr_pipe;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_aid = '0;
  logic [31:0] s_axi_aaddr = '0;
  logic [2:0]  s_axi_aprot = '0;
  logic [3:0]  s_axi_aqos = '0;
  logic        s_axi_avalid = 1'b0;
  logic        s_axi_aready;
  logic [3:0]  m_axi_aregion;
  logic [0:0]  m_select;
  logic        m_axi_avalid;
  logic        m_axi_aready = 1'b1;
  logic [0:0]  m_wc_select;
  logic        m_wc_decerr, m_wc_valid;
  logic        m_wc_ready = 1'b1;
  logic        m_rc_decerr, m_rc_valid;
  logic        m_rc_ready = 1'b1;
  logic [7:0]  s_cpl_id = '0;
  logic        s_cpl_valid = 1'b0;
  logic [2*CW-1:0] m_outstanding;
  logic        cpl_orphan;

  axi_crossbar_addr_pipe #(
    .S(0), .S_COUNT(1), .M_COUNT(2), .ADDR_WIDTH(32), .ID_WIDTH(8),
    .S_THREADS(2), .S_ACCEPT(4), .M_REGIONS(1),
    .M_ADDR_WIDTH({2{32'd24}}),
    .M_ISSUE({32'd2, 32'd0}),
    .WC_OUTPUT(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_aid(s_axi_aid), .s_axi_aaddr(s_axi_aaddr),
    .s_axi_aprot(s_axi_aprot), .s_axi_aqos(s_axi_aqos),
    .s_axi_avalid(s_axi_avalid), .s_axi_aready(s_axi_aready),
    .m_axi_aregion(m_axi_aregion), .m_select(m_select),
    .m_axi_avalid(m_axi_avalid), .m_axi_aready(m_axi_aready),
    .m_wc_select(m_wc_select), .m_wc_decerr(m_wc_decerr),
    .m_wc_valid(m_wc_valid), .m_wc_ready(m_wc_ready),
    .m_rc_decerr(m_rc_decerr), .m_rc_valid(m_rc_valid),
    .m_rc_ready(m_rc_ready),
    .s_cpl_id(s_cpl_id), .s_cpl_valid(s_cpl_valid),
    .m_outstanding(m_outstanding), .cpl_orphan(cpl_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [7:0] id;
    bit       m;
  } txn_t;

  txn_t q[$];
  bit   e_av, e_wv, e_rv, e_dec, e_orph, e_sel;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   last_rdy;
  int   acc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_m(bit mm);
    int n = 0;
    foreach (q[i]) if (q[i].m == mm) n++;
    return n;
  endfunction

  function automatic int find(bit [7:0] id);
    int r = -1;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].id == id) r = i;
    return r;
  endfunction

  function automatic int n_ids();
    int n = 0;
    bit dup;
    foreach (q[i]) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) if (q[j].id == q[i].id) dup = 1'b1;
      if (!dup) n++;
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit vld, input bit [7:0] id,
                      input bit [31:0] addr, input bit mr, input bit wr,
                      input bit rr, input bit cv, input bit [7:0] cid);
    bit free, hit, mm, cm, thr_ok, cap_ok, er;
    int ci, ii, eff_tot, eff_m;
    @(negedge clk);
    rst = r;
    s_axi_avalid = vld;
    s_axi_aid = id;
    s_axi_aaddr = addr;
    s_axi_aprot = 3'($urandom);
    s_axi_aqos = 4'($urandom);
    m_axi_aready = mr;
    m_wc_ready = wr;
    m_rc_ready = rr;
    s_cpl_valid = cv;
    s_cpl_id = cid;
    #1;
    chk("avalid", m_axi_avalid, e_av);
    chk("wc_valid", m_wc_valid, e_wv);
    chk("rc_valid", m_rc_valid, e_rv);
    chk("orphan", cpl_orphan, e_orph);
    chk("out0", m_outstanding[CW-1:0], cnt_m(1'b0));
    chk("out1", m_outstanding[2*CW-1:CW], cnt_m(1'b1));
    if (e_av) begin
      chk("select", m_select, e_sel);
      chk("wc_select", m_wc_select, e_sel);
      chk("region", m_axi_aregion, 0);
    end
    if (e_wv) chk("wc_decerr", m_wc_decerr, e_dec);
    if (e_rv) chk("rc_decerr", m_rc_decerr, 1);

    free = (!e_av || mr) && (!e_wv || wr) && (!e_rv || rr);
    hit = (addr >> 24) < 2;
    mm = addr[24];
    ci = find(cid);
    cm = cv && ci >= 0;
    eff_tot = q.size() - int'(cm);
    eff_m = cnt_m(mm) - int'(cm && q[ci].m == mm);
    cap_ok = (mm == 1'b0) || (eff_m < 2);
    ii = find(id);
    thr_ok = (ii >= 0) ? (q[ii].m == mm) : (n_ids() < 2);
    er = !r && vld && free && (!hit || (eff_tot < 4 && cap_ok && thr_ok));
    chk("aready", s_axi_aready, er);
    last_rdy = s_axi_aready;
    if (last_rdy) acc++;

    if (r) begin
      q.delete();
      {e_av, e_wv, e_rv, e_dec, e_orph, e_sel} = '0;
    end else begin
      if (er) begin
        e_av = hit;
        e_wv = 1'b1;
        e_rv = !hit;
        e_dec = !hit;
        e_sel = mm;
      end else begin
        if (mr) e_av = 1'b0;
        if (wr) e_wv = 1'b0;
        if (rr) e_rv = 1'b0;
      end
      e_orph = cv && ci < 0;
      if (cm) q.delete(ci);
      if (er && hit) q.push_back('{id: id, m: mm});
    end
  endtask

  task automatic go(input bit vld, input bit [7:0] id, input bit [31:0] a);
    step(1'b0, vld, id, a, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0);
  endtask

  task automatic gc(input bit vld, input bit [7:0] id, input bit [31:0] a,
                    input bit [7:0] cid);
    step(1'b0, vld, id, a, 1'b1, 1'b1, 1'b1, 1'b1, cid);
  endtask

  bit [7:0] idt [4] = '{8'h0, 8'h1, 8'h2, 8'h5};

  initial begin
    repeat (3) @(posedge clk);
    go(0, 0, 0);
    chk("rst_aready", s_axi_aready, 0);

    acc = 0;
    repeat (4) go(1, 8'h0, 32'h100);
    chk("tp_acc", acc, 4);
    go(0, 0, 0);
    chk("tp_out0", m_outstanding[CW-1:0], 4);
    repeat (4) gc(0, 0, 0, 8'h0);

    go(1, 8'h5, 32'h10);
    acc = 0;
    repeat (3) go(1, 8'h5, 32'h100_0010);
    gc(1, 8'h5, 32'h100_0010, 8'h5);
    chk("ord_stall", acc, 0);
    go(1, 8'h5, 32'h100_0010);
    chk("ord_acc", last_rdy, 1);
    go(0, 0, 0);
    chk("ord_sel", m_select, 1);
    gc(0, 0, 0, 8'h5);

    go(1, 8'h1, 32'h100_0000);
    go(1, 8'h1, 32'h100_0040);
    go(1, 8'h1, 32'h100_0080);
    chk("cap_stall", last_rdy, 0);
    gc(1, 8'h1, 32'h100_0080, 8'h1);
    chk("cap_acc", last_rdy, 1);
    go(0, 0, 0);
    chk("cap_out1", m_outstanding[2*CW-1:CW], 2);

    go(1, 8'h9, 32'h300_0000);
    go(0, 0, 0);
    chk("dec_rc", {m_rc_valid, m_rc_decerr, m_axi_avalid}, 3'b110);
    chk("dec_wc", {m_wc_valid, m_wc_decerr}, 2'b11);

    go(1, 8'h2, 32'h20);
    go(1, 8'h2, 32'h20);
    go(1, 8'h2, 32'h20);
    chk("full_stall", last_rdy, 0);
    gc(1, 8'h2, 32'h20, 8'h1);
    chk("sim_acc", last_rdy, 1);
    go(0, 0, 0);
    chk("sim_tot", m_outstanding[CW-1:0] + m_outstanding[2*CW-1:CW], 4);

    gc(0, 0, 0, 8'h7F);
    go(0, 0, 0);
    chk("orph_pulse", cpl_orphan, 1);
    go(0, 0, 0);
    chk("orph_clr", cpl_orphan, 0);

    gc(0, 0, 0, 8'h1);
    step(0, 1, 8'h2, 32'h20, 0, 1, 1, 0, 0);
    acc = 0;
    repeat (5) step(0, 1, 8'h2, 32'h24, 0, 1, 1, 0, 0);
    chk("bp_acc", acc, 0);
    chk("bp_av", m_axi_avalid, 1);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    go(0, 0, 0);
    chk("rst_valids", {m_axi_avalid, m_wc_valid, m_rc_valid}, 0);
    chk("rst_out", m_outstanding, 0);
    gc(0, 0, 0, 8'h2);
    go(0, 0, 0);
    chk("rst_orph", cpl_orphan, 1);

    for (int n = 0; n < 3000; n++) begin
      bit [7:0] cid;
      cid = idt[$urandom_range(0, 3)];
      if (q.size() != 0 && $urandom_range(0, 2) != 0)
        cid = q[$urandom_range(0, q.size() - 1)].id;
      if ($urandom_range(0, 15) == 0) cid = 8'h7F;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6,
           idt[$urandom_range(0, 3)],
           {8'($urandom_range(0, 2)), 24'($urandom)},
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 9) < 3,
           cid);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
